// File: rtl/axi4_lite_regbank.sv
// AXI4-Lite slave with a parametrised register bank. Status registers are read-only
// from the bus. Hardware can load any register through i_hw_we/i_hw_wdata.
module axi4_lite_regbank #(
    parameter int                DATA_W  = 32,
    parameter int                ADDR_W  = 32,
    parameter int                N_REGS  = 8,
    parameter logic [N_REGS-1:0] RO_MASK = 'hC0
) (
    input  logic                       ACLK,
    input  logic                       ARSTn,
    input  logic                       AWVALID,
    output logic                       AWREADY,
    input  logic [ADDR_W-1:0]          AWADDR,
    input  logic [2:0]                 AWPROT,
    input  logic                       WVALID,
    output logic                       WREADY,
    input  logic [DATA_W-1:0]          WDATA,
    input  logic [DATA_W/8-1:0]        WSTRB,
    output logic                       BVALID,
    input  logic                       BREADY,
    output logic [1:0]                 BRESP,
    input  logic                       ARVALID,
    output logic                       ARREADY,
    input  logic [ADDR_W-1:0]          ARADDR,
    input  logic [2:0]                 ARPROT,
    output logic                       RVALID,
    input  logic                       RREADY,
    output logic [DATA_W-1:0]          RDATA,
    output logic [1:0]                 RRESP,
    input  logic                       i_is_busy,
    input  logic [N_REGS-1:0]          i_hw_we,
    input  logic [N_REGS*DATA_W-1:0]   i_hw_wdata,
    output logic [N_REGS*DATA_W-1:0]   o_regs,
    output logic [N_REGS-1:0]          o_wr_pulse
);

    localparam int         STRB_W      = DATA_W / 8;
    localparam int         WORD_OFF    = $clog2(STRB_W);
    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_SLVERR = 2'd2;
    localparam logic [1:0] RESP_DECERR = 2'd3;

    logic                aw_held_reg;
    logic [ADDR_W-1:0]   awaddr_reg;
    logic                w_held_reg;
    logic [DATA_W-1:0]   wdata_reg;
    logic [STRB_W-1:0]   wstrb_reg;
    logic                bvalid_reg;
    logic [1:0]          bresp_reg;
    logic [N_REGS-1:0]   wr_pulse_reg;
    logic                rvalid_reg;
    logic [1:0]          rresp_reg;
    logic [DATA_W-1:0]   rdata_reg;

    logic                aw_hs;
    logic                w_hs;
    logic                ar_hs;
    logic                commit;
    logic                wr_ok;
    logic [ADDR_W-1:0]   wr_addr;
    logic [DATA_W-1:0]   wr_data;
    logic [STRB_W-1:0]   wr_strb;
    logic [ADDR_W-1:0]   wr_idx;
    logic [ADDR_W-1:0]   rd_idx;
    logic [N_REGS-1:0]   wr_sel;
    logic [N_REGS-1:0]   rd_sel;
    logic [1:0]          wr_resp;
    logic [DATA_W-1:0]   rd_word;

    // Protection attributes carry no meaning for this bank.
    logic unused_prot;
    assign unused_prot = ^{AWPROT, ARPROT};

    assign AWREADY    = !aw_held_reg && !bvalid_reg;
    assign WREADY     = !w_held_reg && !bvalid_reg;
    assign ARREADY    = !rvalid_reg;
    assign BVALID     = bvalid_reg;
    assign BRESP      = bresp_reg;
    assign RVALID     = rvalid_reg;
    assign RRESP      = rresp_reg;
    assign RDATA      = rdata_reg;
    assign o_wr_pulse = wr_pulse_reg;

    assign aw_hs = AWVALID && AWREADY;
    assign w_hs  = WVALID && WREADY;
    assign ar_hs = ARVALID && ARREADY;

    // A channel is available if already held or handshaking this very cycle.
    assign commit  = (aw_held_reg || aw_hs) && (w_held_reg || w_hs);
    assign wr_addr = aw_held_reg ? awaddr_reg : AWADDR;
    assign wr_data = w_held_reg ? wdata_reg : WDATA;
    assign wr_strb = w_held_reg ? wstrb_reg : WSTRB;
    assign wr_idx  = wr_addr >> WORD_OFF;
    assign rd_idx  = ARADDR >> WORD_OFF;

    generate
        for (genvar gi = 0; gi < N_REGS; gi++) begin : g_sel
            assign wr_sel[gi] = (wr_idx == ADDR_W'(gi));
            assign rd_sel[gi] = (rd_idx == ADDR_W'(gi));
        end
    endgenerate

    always_comb begin
        wr_resp = RESP_OKAY;
        if (wr_sel == '0) begin
            wr_resp = RESP_DECERR;
        end else if (|(wr_sel & RO_MASK) || i_is_busy) begin
            wr_resp = RESP_SLVERR;
        end
    end

    assign wr_ok = commit && (wr_resp == RESP_OKAY);

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < N_REGS; i++) begin
            if (rd_sel[i]) begin
                rd_word = o_regs[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARSTn) begin
        if (!ARSTn) begin
            aw_held_reg  <= 1'b0;
            awaddr_reg   <= '0;
            w_held_reg   <= 1'b0;
            wdata_reg    <= '0;
            wstrb_reg    <= '0;
            bvalid_reg   <= 1'b0;
            bresp_reg    <= RESP_OKAY;
            wr_pulse_reg <= '0;
        end else begin
            if (commit) begin
                aw_held_reg <= 1'b0;
                w_held_reg  <= 1'b0;
                bvalid_reg  <= 1'b1;
                bresp_reg   <= wr_resp;
            end else begin
                if (aw_hs) begin
                    aw_held_reg <= 1'b1;
                    awaddr_reg  <= AWADDR;
                end
                if (w_hs) begin
                    w_held_reg <= 1'b1;
                    wdata_reg  <= WDATA;
                    wstrb_reg  <= WSTRB;
                end
                if (bvalid_reg && BREADY) begin
                    bvalid_reg <= 1'b0;
                end
            end
            wr_pulse_reg <= wr_ok ? wr_sel : '0;
        end
    end

    // Bus write takes precedence over a simultaneous hardware load.
    generate
        for (genvar gi = 0; gi < N_REGS; gi++) begin : g_reg
            logic [DATA_W-1:0] value_reg;

            always_ff @(posedge ACLK or negedge ARSTn) begin
                if (!ARSTn) begin
                    value_reg <= '0;
                end else if (wr_ok && wr_sel[gi]) begin
                    for (int b = 0; b < STRB_W; b++) begin
                        if (wr_strb[b]) begin
                            value_reg[b*8 +: 8] <= wr_data[b*8 +: 8];
                        end
                    end
                end else if (i_hw_we[gi]) begin
                    value_reg <= i_hw_wdata[gi*DATA_W +: DATA_W];
                end
            end

            assign o_regs[gi*DATA_W +: DATA_W] = value_reg;
        end
    endgenerate

    always_ff @(posedge ACLK or negedge ARSTn) begin
        if (!ARSTn) begin
            rvalid_reg <= 1'b0;
            rresp_reg  <= RESP_OKAY;
            rdata_reg  <= '0;
        end else if (ar_hs) begin
            rvalid_reg <= 1'b1;
            rresp_reg  <= (rd_sel == '0) ? RESP_DECERR : RESP_OKAY;
            rdata_reg  <= rd_word;
        end else if (rvalid_reg && RREADY) begin
            rvalid_reg <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axi4_lite_regbank.sv
// Self-checking bench for axi4_lite_regbank: directed scenarios followed by
// randomized traffic checked against an array-based register model.
module tb_axi4_lite_regbank;

    localparam int NR = 8;

    logic        ACLK = 1'b0;
    logic        ARSTn = 1'b0;
    logic        AWVALID = 1'b0;
    logic        AWREADY;
    logic [31:0] AWADDR = '0;
    logic [2:0]  AWPROT = '0;
    logic        WVALID = 1'b0;
    logic        WREADY;
    logic [31:0] WDATA = '0;
    logic [3:0]  WSTRB = '0;
    logic        BVALID;
    logic        BREADY = 1'b1;
    logic [1:0]  BRESP;
    logic        ARVALID = 1'b0;
    logic        ARREADY;
    logic [31:0] ARADDR = '0;
    logic [2:0]  ARPROT = '0;
    logic        RVALID;
    logic        RREADY = 1'b1;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        i_is_busy = 1'b0;
    logic [NR-1:0]    i_hw_we = '0;
    logic [NR*32-1:0] i_hw_wdata = '0;
    logic [NR*32-1:0] o_regs;
    logic [NR-1:0]    o_wr_pulse;

    axi4_lite_regbank dut (
        .ACLK(ACLK), .ARSTn(ARSTn),
        .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWPROT(AWPROT),
        .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
        .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
        .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARPROT(ARPROT),
        .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP),
        .i_is_busy(i_is_busy), .i_hw_we(i_hw_we), .i_hw_wdata(i_hw_wdata),
        .o_regs(o_regs), .o_wr_pulse(o_wr_pulse)
    );

    always #5 ACLK = ~ACLK;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] mdl [NR];
    logic [7:0]  ro_mask = 8'hC0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: index = addr/4, then range, read-only, busy, byte-lane merge.
    function automatic logic [1:0] model_write(input logic [31:0] addr, input logic [31:0] data,
                                               input logic [3:0] strb, input logic busy);
        int idx;
        idx = int'(addr >> 2);
        if (idx >= NR) return 2'd3;
        if (ro_mask[idx] || busy) return 2'd2;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) mdl[idx][b*8 +: 8] = data[b*8 +: 8];
        end
        return 2'd0;
    endfunction

    function automatic logic [7:0] model_pulse(input logic [31:0] addr, input logic [1:0] resp);
        logic [7:0] p;
        p = '0;
        if (resp == 2'd0) p[int'(addr >> 2)] = 1'b1;
        return p;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] addr);
        int idx;
        idx = int'(addr >> 2);
        return (idx >= NR) ? 32'h0 : mdl[idx];
    endfunction

    task automatic check_bank(input string tag);
        for (int i = 0; i < NR; i++) begin
            check(tag, 64'(o_regs[i*32 +: 32]), 64'(mdl[i]));
        end
    endtask

    // Called at a negedge; returns at the negedge after the B handshake.
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input logic busy, input int aw_dly, input int w_dly,
                            output logic [1:0] resp, output logic [7:0] pulse);
        bit aw_done, w_done, aw_go, w_go;
        aw_done = 0;
        w_done  = 0;
        AWADDR = addr;
        WDATA = data;
        WSTRB = strb;
        i_is_busy = busy;
        for (int k = 0; k < 30 && !(aw_done && w_done); k++) begin
            AWVALID = !aw_done && (k >= aw_dly);
            WVALID  = !w_done && (k >= w_dly);
            aw_go = AWVALID && AWREADY;
            w_go  = WVALID && WREADY;
            @(posedge ACLK);
            @(negedge ACLK);
            if (aw_go) aw_done = 1;
            if (w_go) w_done = 1;
        end
        AWVALID = 1'b0;
        WVALID = 1'b0;
        i_is_busy = 1'b0;
        if (!(aw_done && w_done)) check("wr_handshake_timeout", 64'(0), 64'(1));
        check("bvalid_latency", 64'(BVALID), 64'(1));
        resp = BRESP;
        pulse = o_wr_pulse;
        $display("wr addr=%h data=%h strb=%h busy=%0d resp=%0d", addr, data, strb, busy, BRESP);
        @(negedge ACLK);
    endtask

    task automatic do_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
        bit done, go;
        done = 0;
        ARADDR = addr;
        for (int k = 0; k < 20 && !done; k++) begin
            ARVALID = 1'b1;
            go = ARREADY;
            @(posedge ACLK);
            @(negedge ACLK);
            if (go) done = 1;
        end
        ARVALID = 1'b0;
        if (!done) check("rd_handshake_timeout", 64'(0), 64'(1));
        check("rvalid_latency", 64'(RVALID), 64'(1));
        data = RDATA;
        resp = RRESP;
        $display("rd addr=%h data=%h resp=%0d", addr, RDATA, RRESP);
        @(negedge ACLK);
    endtask

    task automatic hw_load(input int r, input logic [31:0] data);
        i_hw_we = '0;
        i_hw_we[r] = 1'b1;
        i_hw_wdata[r*32 +: 32] = data;
        @(negedge ACLK);
        i_hw_we = '0;
        mdl[r] = data;
        $display("hw reg=%0d data=%h", r, data);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0]  resp;
        logic [7:0]  pulse;
        logic [31:0] data;
        logic [1:0]  exp_resp;

        for (int i = 0; i < NR; i++) mdl[i] = '0;
        repeat (3) @(negedge ACLK);
        check("reset_awready", 64'(AWREADY), 64'(1));
        check("reset_wready", 64'(WREADY), 64'(1));
        check("reset_arready", 64'(ARREADY), 64'(1));
        check("reset_bvalid", 64'(BVALID), 64'(0));
        check("reset_rvalid", 64'(RVALID), 64'(0));
        check("reset_rdata", 64'(RDATA), 64'(0));
        check("reset_regs", 64'(|o_regs), 64'(0));
        ARSTn = 1'b1;
        @(negedge ACLK);

        // AW and W together.
        do_write(32'h0, 32'hAAAA, 4'hF, 1'b0, 0, 0, resp, pulse);
        void'(model_write(32'h0, 32'hAAAA, 4'hF, 1'b0));
        check("wr0_bresp", 64'(resp), 64'(0));
        check("wr0_pulse", 64'(pulse), 64'(8'h01));
        check("wr0_reg0", 64'(o_regs[31:0]), 64'(32'hAAAA));
        check("wr0_pulse_one_cycle", 64'(o_wr_pulse), 64'(0));
        check("wr0_b_released", 64'(BVALID), 64'(0));

        // W three cycles ahead of AW.
        WVALID = 1'b1; WDATA = 32'h1234; WSTRB = 4'h3;
        @(posedge ACLK);
        @(negedge ACLK);
        WVALID = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("wfirst_wready", 64'(WREADY), 64'(0));
            check("wfirst_awready", 64'(AWREADY), 64'(1));
            check("wfirst_bvalid", 64'(BVALID), 64'(0));
            if (k < 2) @(negedge ACLK);
        end
        AWVALID = 1'b1; AWADDR = 32'h4;
        @(posedge ACLK);
        @(negedge ACLK);
        AWVALID = 1'b0;
        void'(model_write(32'h4, 32'h1234, 4'h3, 1'b0));
        check("wfirst_bvalid_commit", 64'(BVALID), 64'(1));
        check("wfirst_bresp", 64'(BRESP), 64'(0));
        check("wfirst_reg1", 64'(o_regs[63:32]), 64'(32'h0000_1234));
        check("wfirst_pulse", 64'(o_wr_pulse), 64'(8'h02));
        @(negedge ACLK);

        // Read-only register, then hardware load and read back.
        do_write(32'h18, 32'h1111_2222, 4'hF, 1'b0, 0, 1, resp, pulse);
        check("ro_bresp", 64'(resp), 64'(2));
        check("ro_pulse", 64'(pulse), 64'(0));
        check("ro_reg6", 64'(o_regs[6*32 +: 32]), 64'(0));
        hw_load(6, 32'hBEEF);
        do_read(32'h18, data, resp);
        check("ro_rdata", 64'(data), 64'(32'hBEEF));
        check("ro_rresp", 64'(resp), 64'(0));

        // Out of range and busy.
        do_write(32'h40, 32'hDEAD_BEEF, 4'hF, 1'b0, 1, 0, resp, pulse);
        check("oor_bresp", 64'(resp), 64'(3));
        do_read(32'h40, data, resp);
        check("oor_rdata", 64'(data), 64'(0));
        check("oor_rresp", 64'(resp), 64'(3));
        do_write(32'h8, 32'h5A5A_5A5A, 4'hF, 1'b1, 0, 0, resp, pulse);
        check("busy_bresp", 64'(resp), 64'(2));
        check("busy_reg2", 64'(o_regs[2*32 +: 32]), 64'(0));
        check_bank("bank_after_directed");

        // Stall B and R for five cycles with new requests waiting.
        BREADY = 1'b0; RREADY = 1'b0;
        AWVALID = 1'b1; AWADDR = 32'hC; WVALID = 1'b1; WDATA = 32'h5555_0000; WSTRB = 4'hF;
        ARVALID = 1'b1; ARADDR = 32'h0;
        @(posedge ACLK);
        @(negedge ACLK);
        void'(model_write(32'hC, 32'h5555_0000, 4'hF, 1'b0));
        AWADDR = 32'h10; WDATA = 32'h7777_7777; ARADDR = 32'h4;
        for (int k = 0; k < 5; k++) begin
            check("stall_bvalid", 64'(BVALID), 64'(1));
            check("stall_bresp", 64'(BRESP), 64'(0));
            check("stall_rvalid", 64'(RVALID), 64'(1));
            check("stall_rdata", 64'(RDATA), 64'(32'hAAAA));
            check("stall_rresp", 64'(RRESP), 64'(0));
            check("stall_readies", 64'({AWREADY, WREADY, ARREADY}), 64'(0));
            check("stall_pulse", 64'(o_wr_pulse), 64'((k == 0) ? 8'h08 : 8'h00));
            @(negedge ACLK);
        end
        AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
        BREADY = 1'b1; RREADY = 1'b1;
        @(negedge ACLK);
        check("stall_b_released", 64'(BVALID), 64'(0));
        check("stall_r_released", 64'(RVALID), 64'(0));
        check_bank("bank_after_stall");

        // Reset with AW held and W about to handshake.
        AWVALID = 1'b1; AWADDR = 32'h14;
        @(posedge ACLK);
        @(negedge ACLK);
        AWVALID = 1'b0;
        check("midrst_aw_held", 64'(AWREADY), 64'(0));
        WVALID = 1'b1; WDATA = 32'hCAFE_F00D; WSTRB = 4'hF;
        ARSTn = 1'b0;
        #1;
        WVALID = 1'b0;
        repeat (2) @(negedge ACLK);
        ARSTn = 1'b1;
        @(negedge ACLK);
        for (int i = 0; i < NR; i++) mdl[i] = '0;
        check("midrst_bvalid", 64'(BVALID), 64'(0));
        check("midrst_awready", 64'(AWREADY), 64'(1));
        check("midrst_pulse", 64'(o_wr_pulse), 64'(0));
        check_bank("bank_after_reset");
        do_write(32'h14, 32'h0BAD_CAFE, 4'hF, 1'b0, 0, 0, resp, pulse);
        void'(model_write(32'h14, 32'h0BAD_CAFE, 4'hF, 1'b0));
        check("midrst_new_bresp", 64'(resp), 64'(0));
        check("midrst_new_reg5", 64'(o_regs[5*32 +: 32]), 64'(32'h0BAD_CAFE));

        // Randomized traffic against the model.
        for (int t = 0; t < 80; t++) begin
            int op;
            logic [31:0] addr, wd;
            logic [3:0] strb;
            logic busy;
            op = $urandom_range(0, 2);
            addr = 32'($urandom_range(0, 11)) * 4 + 32'($urandom_range(0, 3));
            if (op == 0) begin
                wd = $urandom;
                strb = 4'($urandom_range(0, 15));
                busy = ($urandom_range(0, 3) == 0);
                do_write(addr, wd, strb, busy, $urandom_range(0, 2), $urandom_range(0, 2), resp, pulse);
                exp_resp = model_write(addr, wd, strb, busy);
                check("rand_bresp", 64'(resp), 64'(exp_resp));
                check("rand_pulse", 64'(pulse), 64'(model_pulse(addr, exp_resp)));
                check_bank("rand_bank");
            end else if (op == 1) begin
                do_read(addr, data, resp);
                check("rand_rdata", 64'(data), 64'(model_read(addr)));
                check("rand_rresp", 64'(resp), 64'((int'(addr >> 2) >= NR) ? 2'd3 : 2'd0));
            end else begin
                int r;
                r = $urandom_range(0, NR - 1);
                hw_load(r, $urandom);
                check("rand_hw", 64'(o_regs[r*32 +: 32]), 64'(mdl[r]));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
